// File: rtl/loader_pkg.sv
// Shared types and helpers for the serial program loader.
// Holds the session state encoding, the sync byte and the bit-timing helper.
package loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_BYTE,
        ADDR,
        GAP,
        DATA,
        CHECK,
        FINISH
    } loader_state_t;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 LSB-first receiver with 2-flop synchronizer and glitch-rejecting start check.
// Emits one-clk byte_valid or frame_err after sampling the stop bit.
module uart_rx #(
    parameter int CLKS_PER_BIT = 234
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       frame_err
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;

    rx_state_t      rs;
    logic           rx_m;
    logic           rx_s;
    logic           rx_d;
    logic [CW-1:0]  cnt;
    logic [2:0]     bitn;
    logic [7:0]     sh;

    assign rx_byte = sh;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_m       <= 1'b1;
            rx_s       <= 1'b1;
            rx_d       <= 1'b1;
            rs         <= R_IDLE;
            cnt        <= '0;
            bitn       <= '0;
            sh         <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_m       <= rx;
            rx_s       <= rx_m;
            rx_d       <= rx_s;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            unique case (rs)
                R_IDLE: begin
                    if (rx_d && !rx_s) begin
                        rs  <= R_START;
                        cnt <= '0;
                    end
                end
                R_START: begin
                    if (cnt == HALF) begin
                        cnt  <= '0;
                        bitn <= '0;
                        rs   <= rx_s ? R_IDLE : R_DATA;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                R_DATA: begin
                    if (cnt == FULL) begin
                        cnt  <= '0;
                        sh   <= {rx_s, sh[7:1]};
                        bitn <= bitn + 3'd1;
                        if (bitn == 3'd7) rs <= R_STOP;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                R_STOP: begin
                    if (cnt == FULL) begin
                        rs <= R_IDLE;
                        // a low stop bit discards the byte
                        if (rx_s) byte_valid <= 1'b1;
                        else      frame_err  <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: rs <= R_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/program_loader.sv
// Serial loader writing MEM_DEPTH bytes into RAM via the MAR/RAM manual path.
// Define LOADER_CHECKSUM_EN to require a trailing 8-bit sum byte per session.
module program_loader #(
    parameter int CLK_FREQ     = 27_000_000,
    parameter int BAUD         = 115200,
    parameter int MEM_DEPTH    = 16,
    parameter int TIMEOUT_CLKS = 2_700_000
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         rx,
    output logic                         prog_mode,
    output logic [$clog2(MEM_DEPTH)-1:0] prog_addr,
    output logic [7:0]                   prog_data,
    output logic                         prog_addr_strobe,
    output logic                         prog_data_strobe,
    output logic                         done,
    output logic                         error
);

    import loader_pkg::*;

    localparam int AW  = $clog2(MEM_DEPTH);
    localparam int TW  = $clog2(TIMEOUT_CLKS + 1);
    localparam int CPB = clks_per_bit(CLK_FREQ, BAUD);

    loader_state_t state;
    loader_state_t state_n;
    logic [7:0]    rx_byte;
    logic          byte_valid;
    logic          frame_err;
    logic [TW-1:0] tmo;
    logic          timeout;
    logic          last;
    logic          start;
    logic          latch;
    logic          step;
    logic          set_done;
    logic          set_err;

    uart_rx #(.CLKS_PER_BIT(CPB)) u_rx (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .rx_byte    (rx_byte),
        .byte_valid (byte_valid),
        .frame_err  (frame_err)
    );

    assign timeout          = tmo >= TW'(TIMEOUT_CLKS);
    assign last             = prog_addr == AW'(MEM_DEPTH - 1);
    assign prog_mode        = (state != IDLE) && (state != FINISH);
    assign prog_addr_strobe = state == ADDR;
    assign prog_data_strobe = state == DATA;

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] sum;
`endif

    always_comb begin
        state_n  = state;
        start    = 1'b0;
        latch    = 1'b0;
        step     = 1'b0;
        set_done = 1'b0;
        set_err  = 1'b0;
        unique case (state)
            IDLE: begin
                if (byte_valid && rx_byte == SYNC_BYTE) begin
                    start   = 1'b1;
                    state_n = WAIT_BYTE;
                end
            end
            WAIT_BYTE: begin
                if (byte_valid) begin
                    latch   = 1'b1;
                    state_n = ADDR;
                end else if (frame_err || timeout) begin
                    set_err = 1'b1;
                    state_n = IDLE;
                end
            end
            ADDR: state_n = GAP;
            GAP:  state_n = DATA;
            DATA: begin
                if (last) begin
`ifdef LOADER_CHECKSUM_EN
                    state_n = CHECK;
`else
                    state_n = FINISH;
`endif
                end else begin
                    step    = 1'b1;
                    state_n = WAIT_BYTE;
                end
            end
            CHECK: begin
`ifdef LOADER_CHECKSUM_EN
                if (byte_valid && rx_byte == sum) begin
                    state_n = FINISH;
                end else if (byte_valid || frame_err || timeout) begin
                    set_err = 1'b1;
                    state_n = IDLE;
                end
`else
                state_n = IDLE;
`endif
            end
            FINISH: begin
                set_done = 1'b1;
                state_n  = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            prog_addr <= '0;
            prog_data <= '0;
            done      <= 1'b0;
            error     <= 1'b0;
            tmo       <= '0;
        end else begin
            state <= state_n;
            if (start) begin
                prog_addr <= '0;
                done      <= 1'b0;
                error     <= 1'b0;
            end
            if (latch)    prog_data <= rx_byte;
            if (step)     prog_addr <= prog_addr + AW'(1);
            if (set_done) done      <= 1'b1;
            if (set_err)  error     <= 1'b1;
            // idle time is measured from the most recent complete byte
            if (byte_valid)                tmo <= '0;
            else if (prog_mode && !timeout) tmo <= tmo + TW'(1);
        end
    end

`ifdef LOADER_CHECKSUM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)             sum <= '0;
        else if (start)         sum <= '0;
        else if (state == DATA) sum <= sum + prog_data;
    end
`endif

endmodule
